// File: rtl/sum_tx_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// sum_tx_pkg
// Shared definitions for the sum report sequencer:
//   - state_t    : sequencer FSM states
//   - CH_*       : fixed ASCII characters used in the report frame
//   - FRAME_LEN  : number of bytes per frame
//   - LAST_IDX   : byte index of the final byte of a frame
// Build option: define SUM_TX_CRLF_EN to append CR LF to every frame
// (8 bytes); leave it undefined for the bare 6-byte frame.
// ---------------------------------------------------------------------------
package sum_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        DONE
    } state_t;

    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_EQ   = 8'h3D;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

`ifdef SUM_TX_CRLF_EN
    localparam int FRAME_LEN = 8;
`else
    localparam int FRAME_LEN = 6;
`endif

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

endpackage

// File: rtl/sum_tx_sequencer_if.sv
// ---------------------------------------------------------------------------
// sum_tx_sequencer_if
// Bundles the operand/sum latch inputs, the UART transmitter handshake and
// the frame status flags of the sum report sequencer.
//   start    : request one frame
//   a_val    : latched operand A (4 bits)
//   b_val    : latched operand B (4 bits)
//   sum_val  : A+B from the adder (5 bits)
//   tx_busy  : UART transmitter busy
//   tx_data  : byte presented to the UART (8 bits)
//   tx_en    : one-cycle load strobe to the UART
//   busy     : frame in progress
//   done     : one-cycle pulse after the last byte completes
//   err      : sticky ack-timeout flag
// Modports: master = the sequencer, slave = its surroundings.
// ---------------------------------------------------------------------------
interface sum_tx_sequencer_if;

    logic       start;
    logic [3:0] a_val;
    logic [3:0] b_val;
    logic [4:0] sum_val;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, a_val, b_val, sum_val, tx_busy,
        output tx_data, tx_en, busy, done, err
    );

    modport slave (
        output start, a_val, b_val, sum_val, tx_busy,
        input  tx_data, tx_en, busy, done, err
    );

endinterface

// File: rtl/sum_tx_sequencer_nib2ascii.sv
// ---------------------------------------------------------------------------
// nib2ascii
// Combinational encoder from a 4-bit nibble to its uppercase ASCII hex digit.
//   nib_i   : nibble to encode
//   ascii_o : '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
// ---------------------------------------------------------------------------
module nib2ascii (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    // Digits start at '0'; letters start at 'A', i.e. 0x41 - 10 = 0x37.
    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nib_i};
        end else begin
            ascii_o = 8'h37 + {4'h0, nib_i};
        end
    end

endmodule

// File: rtl/sum_tx_sequencer.sv
// ---------------------------------------------------------------------------
// sum_tx_sequencer
// Owns the UART transmitter of the sum-latch system. On start it snapshots
// A, B and the sum, then sends the ASCII frame "<A>+<B>=<sumHi><sumLo>"
// (optionally followed by CR LF) one byte at a time, handshaking on the
// transmitter's busy flag.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : sum_tx_sequencer_if.master (operands, UART handshake, status)
// Parameter:
//   ACK_TIMEOUT : cycles allowed for tx_busy to rise after tx_en
// Build option: SUM_TX_CRLF_EN appends CR LF to the frame.
// ---------------------------------------------------------------------------
module sum_tx_sequencer
    import sum_tx_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input logic          clk,
    input logic          reset_n,
    sum_tx_sequencer_if.master bus
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic [4:0]       sum_q;
    logic [7:0]       txData_q;
    logic             txEn_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [7:0]       aChar;
    logic [7:0]       bChar;
    logic [7:0]       sumLoChar;
    logic [7:0]       sumHiChar;
    logic [7:0]       byte_d;

    // Hex encoders work on the snapshot, so operand changes mid-frame
    // cannot leak into the bytes still to be sent.
    nib2ascii uEncA   (.nib_i(a_q),        .ascii_o(aChar));
    nib2ascii uEncB   (.nib_i(b_q),        .ascii_o(bChar));
    nib2ascii uEncSum (.nib_i(sum_q[3:0]), .ascii_o(sumLoChar));

    assign sumHiChar = sum_q[4] ? 8'h31 : 8'h30;

    // Byte mux: picks the frame byte for the current index.
    always_comb begin
        byte_d = 8'h00;
        case (idx_q)
            3'd0:    byte_d = aChar;
            3'd1:    byte_d = CH_PLUS;
            3'd2:    byte_d = bChar;
            3'd3:    byte_d = CH_EQ;
            3'd4:    byte_d = sumHiChar;
            3'd5:    byte_d = sumLoChar;
`ifdef SUM_TX_CRLF_EN
            3'd6:    byte_d = CH_CR;
            3'd7:    byte_d = CH_LF;
`endif
            default: byte_d = 8'h00;
        endcase
    end

    // Frame sequencer. tx_en and done default low every cycle so each is a
    // single-cycle pulse. The ack counter is zeroed when a byte is issued;
    // err fires on the ACK_TIMEOUT-th cycle after tx_en without tx_busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            cnt_q    <= '0;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            sum_q    <= 5'h00;
            txData_q <= 8'h00;
            txEn_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            txEn_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a_val;
                        b_q     <= bus.b_val;
                        sum_q   <= bus.sum_val;
                        idx_q   <= 3'd0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.tx_busy) begin
                        txEn_q   <= 1'b1;
                        txData_q <= byte_d;
                        cnt_q    <= '0;
                        state_q  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data = txData_q;
    assign bus.tx_en   = txEn_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sum_tx_sequencer
// Directed bench for sum_tx_sequencer. Stimulus pushes the hand-computed
// frame bytes (plus a done marker) into a queue; a separate monitor, which
// also models the UART busy flag, pops and compares whenever tx_en or done
// shows up. Honors SUM_TX_CRLF_EN for the expected frame tail.
// ---------------------------------------------------------------------------
module tb_sum_tx_sequencer;

    localparam int         ACK_TIMEOUT = 16;
    localparam int         UART_BUSY   = 10;
    localparam logic [8:0] DONE_TOKEN  = 9'h100;

    logic clk = 1'b0;
    logic reset_n;

    sum_tx_sequencer_if bus ();

    sum_tx_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int         testsRun    = 0;
    int         testsFailed = 0;
    int         txCount     = 0;
    int         doneCount   = 0;
    logic       uartStuck   = 1'b0;
    logic [8:0] expQ[$];

    // Single comparison with pass/fail bookkeeping.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    // Queue one expected frame followed by the done marker.
    task automatic pushFrame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        expQ.push_back({1'b0, b0});
        expQ.push_back({1'b0, b1});
        expQ.push_back({1'b0, b2});
        expQ.push_back({1'b0, b3});
        expQ.push_back({1'b0, b4});
        expQ.push_back({1'b0, b5});
`ifdef SUM_TX_CRLF_EN
        expQ.push_back(9'h00D);
        expQ.push_back(9'h00A);
`endif
        expQ.push_back(DONE_TOKEN);
    endtask

    // Present operands and pulse start for one cycle; busy must rise and
    // err must clear on the accepting edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
        @(negedge clk);
        bus.a_val   = a;
        bus.b_val   = b;
        bus.sum_val = s;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busyAfterStart", 32'(bus.busy), 32'd1);
        checkOutput("errClearedOnStart", 32'(bus.err), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n = 0;
        while (doneCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("doneSeen", 32'(doneCount >= target), 32'd1);
    endtask

    task automatic waitTx(input int target, input int budget);
        int n = 0;
        while (txCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("txSeen", 32'(txCount >= target), 32'd1);
    endtask

    // Monitor plus UART model: sampled on the falling edge, away from the
    // DUT's active edge. The tx_en/tx_busy overlap check runs before the
    // model raises busy for the new byte.
    initial begin : monitor
        int         uartLeft;
        logic [8:0] exp;
        uartLeft = 0;
        forever begin
            @(negedge clk);
            if (bus.tx_en === 1'b1) begin
                checkOutput("txEnWhileBusy", 32'(bus.tx_busy), 32'd0);
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedByte: got 0x%0h, required no byte", bus.tx_data);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("txByte", 32'({1'b0, bus.tx_data}), 32'(exp));
                end
                txCount++;
                if (!uartStuck) begin
                    bus.tx_busy = 1'b1;
                    uartLeft    = UART_BUSY;
                end
            end else if (uartLeft > 0) begin
                uartLeft--;
                if (uartLeft == 0) bus.tx_busy = 1'b0;
            end
            if (bus.done === 1'b1) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedDone: got done, required none");
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("donePosition", 32'(exp), 32'(DONE_TOKEN));
                end
                doneCount++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int txMark;
        bus.start   = 1'b0;
        bus.a_val   = 4'h0;
        bus.b_val   = 4'h0;
        bus.sum_val = 5'h00;
        bus.tx_busy = 1'b0;
        reset_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstTxData", 32'(bus.tx_data), 32'h00);
        checkOutput("rstTxEn",   32'(bus.tx_en),   32'd0);
        checkOutput("rstBusy",   32'(bus.busy),    32'd0);
        checkOutput("rstDone",   32'(bus.done),    32'd0);
        checkOutput("rstErr",    32'(bus.err),     32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 3 + 5 = 8
        pushFrame(8'h33, 8'h2B, 8'h35, 8'h3D, 8'h30, 8'h38);
        applyStimulus(4'h3, 4'h5, 5'h08);
        waitDone(1, 300);
        #1;
        checkOutput("busyLowAfterDone", 32'(bus.busy), 32'd0);
        checkOutput("donePulseOneCycle", 32'(bus.done), 32'd0);
        checkOutput("errAfterFrame1", 32'(bus.err), 32'd0);

        // F + F = 1E
        pushFrame(8'h46, 8'h2B, 8'h46, 8'h3D, 8'h31, 8'h45);
        applyStimulus(4'hF, 4'hF, 5'h1E);
        waitDone(2, 300);
        #1;
        checkOutput("errAfterFrame2", 32'(bus.err), 32'd0);

        // A + 6 = 10, with operand changes and a second start mid-frame
        pushFrame(8'h41, 8'h2B, 8'h36, 8'h3D, 8'h31, 8'h30);
        txMark = txCount;
        applyStimulus(4'hA, 4'h6, 5'h10);
        waitTx(txMark + 2, 200);
        @(negedge clk);
        bus.a_val   = 4'h1;
        bus.b_val   = 4'h2;
        bus.sum_val = 5'h03;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        waitDone(3, 300);
        txMark = txCount;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("noQueuedFrameBusy", 32'(bus.busy), 32'd0);
        checkOutput("noQueuedFrameBytes", 32'(txCount), 32'(txMark));

        // tx_busy stuck low: ack timeout
        uartStuck = 1'b1;
        expQ.push_back(9'h039);
        applyStimulus(4'h9, 4'h0, 5'h09);
        begin
            int n = 0;
            while (bus.tx_en !== 1'b1 && n < 5) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        checkOutput("firstTxEnTimeout", 32'(bus.tx_en), 32'd1);
        for (int j = 1; j <= ACK_TIMEOUT; j++) begin
            @(posedge clk);
            #1;
            if (j == ACK_TIMEOUT - 1) begin
                checkOutput("errBeforeTimeout", 32'(bus.err), 32'd0);
                checkOutput("busyBeforeTimeout", 32'(bus.busy), 32'd1);
            end
            if (j == ACK_TIMEOUT) begin
                checkOutput("errAtTimeout", 32'(bus.err), 32'd1);
                checkOutput("busyAtTimeout", 32'(bus.busy), 32'd0);
            end
        end
        repeat (5) @(posedge clk);
        checkOutput("noDoneOnTimeout", 32'(doneCount), 32'd3);
        uartStuck = 1'b0;

        // Next start clears err and runs a full frame: 9 + 0 = 9
        pushFrame(8'h39, 8'h2B, 8'h30, 8'h3D, 8'h30, 8'h39);
        applyStimulus(4'h9, 4'h0, 5'h09);
        waitDone(4, 300);

        // Reset during byte 4
        pushFrame(8'h33, 8'h2B, 8'h35, 8'h3D, 8'h30, 8'h38);
        txMark = txCount;
        applyStimulus(4'h3, 4'h5, 5'h08);
        waitTx(txMark + 5, 200);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midRstTxData", 32'(bus.tx_data), 32'h00);
        checkOutput("midRstTxEn",   32'(bus.tx_en),   32'd0);
        checkOutput("midRstBusy",   32'(bus.busy),    32'd0);
        checkOutput("midRstDone",   32'(bus.done),    32'd0);
        checkOutput("midRstErr",    32'(bus.err),     32'd0);
        expQ.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        checkOutput("noDoneAfterReset", 32'(doneCount), 32'd4);

        // Full frame after reset: A + 6 = 10
        pushFrame(8'h41, 8'h2B, 8'h36, 8'h3D, 8'h31, 8'h30);
        applyStimulus(4'hA, 4'h6, 5'h10);
        waitDone(5, 300);

        repeat (5) @(posedge clk);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
